// File: rtl/riscv_if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills the
// single-entry IF/ID register, with EX/ID redirects taking priority over stall.
module riscv_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [1:0]       JumpFlag,
  input  logic [31:0]      JumpTarget_id,
  input  logic [31:0]      JumpTarget_ex,
  input  logic [31:0]      Imem_data,
  output logic [31:0]      Imem_addr,
  output logic [31:0]      PC,
  output logic [31:0]      PC_id,
  output logic [31:0]      PC4_id,
  output logic [31:0]      Instruction_id,
  output logic             Valid_id,
  output logic [CNT_W-1:0] FetchCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        fetch;

  always_comb begin
    pc_plus4        = pc_q + 32'd4;
    redirect        = |JumpFlag;
    // EX holds the older instruction, so its redirect wins over ID's.
    redirect_target = JumpFlag[1] ? JumpTarget_ex : JumpTarget_id;
    fetch           = !redirect && !Stall;
    pc_next         = pc_q;
    if (redirect) begin
      pc_next = {redirect_target[31:2], 2'b00};
    end else if (fetch) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // A bubble reloads IF/ID with the same contents it has out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_id          <= 32'd0;
      PC4_id         <= 32'd4;
      Instruction_id <= NOP_INSTR;
      Valid_id       <= 1'b0;
    end else if (redirect) begin
      PC_id          <= 32'd0;
      PC4_id         <= 32'd4;
      Instruction_id <= NOP_INSTR;
      Valid_id       <= 1'b0;
    end else if (fetch) begin
      PC_id          <= pc_q;
      PC4_id         <= pc_plus4;
      Instruction_id <= Imem_data;
      Valid_id       <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FetchCount <= '0;
    end else if (fetch) begin
      FetchCount <= FetchCount + CNT_ONE;
    end
  end

  assign Imem_addr = pc_q;
  assign PC        = pc_q;

endmodule

// File: tb/tb_riscv_if_stage.sv
// Directed and randomized checks of riscv_if_stage against a cycle-level
// reference model of the fetch rules.
module tb_riscv_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             Stall = 1'b0;
  logic [1:0]       JumpFlag = 2'b00;
  logic [31:0]      JumpTarget_id = 32'd0;
  logic [31:0]      JumpTarget_ex = 32'd0;
  logic [31:0]      Imem_data;
  logic [31:0]      Imem_addr;
  logic [31:0]      PC;
  logic [31:0]      PC_id;
  logic [31:0]      PC4_id;
  logic [31:0]      Instruction_id;
  logic             Valid_id;
  logic [CNT_W-1:0] FetchCount;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_pc, m_pc_id, m_pc4, m_instr;
  logic        m_valid;
  int          m_cnt;

  riscv_if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Stall         (Stall),
    .JumpFlag      (JumpFlag),
    .JumpTarget_id (JumpTarget_id),
    .JumpTarget_ex (JumpTarget_ex),
    .Imem_data     (Imem_data),
    .Imem_addr     (Imem_addr),
    .PC            (PC),
    .PC_id         (PC_id),
    .PC4_id        (PC4_id),
    .Instruction_id(Instruction_id),
    .Valid_id      (Valid_id),
    .FetchCount    (FetchCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  assign Imem_data = tag(Imem_addr);

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_pc_id = 32'd0;
    m_pc4   = 32'd4;
    m_instr = NOP_INSTR;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ".PC"},        PC,             m_pc);
    chk({where, ".Imem_addr"}, Imem_addr,      m_pc);
    chk({where, ".PC_id"},     PC_id,          m_pc_id);
    chk({where, ".PC4_id"},    PC4_id,         m_pc4);
    chk({where, ".Instr_id"},  Instruction_id, m_instr);
    chk({where, ".Valid_id"},  {31'd0, Valid_id}, {31'd0, m_valid});
    chk({where, ".FetchCnt"},  {16'd0, FetchCount}, m_cnt % (1 << CNT_W));
  endtask

  // drive inputs (at a falling edge), take one rising edge, then compare
  task automatic step(input string where, input logic st, input logic [1:0] jf,
                      input logic [31:0] tid, input logic [31:0] tex);
    Stall         = st;
    JumpFlag      = jf;
    JumpTarget_id = tid;
    JumpTarget_ex = tex;
    @(posedge clk);
    if (jf[1] || jf[0]) begin
      m_pc    = (jf[1] ? tex : tid) & 32'hFFFF_FFFC;
      m_pc_id = 32'd0;
      m_pc4   = 32'd4;
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = tag(m_pc);
      m_pc_id = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 1;
    end
    @(negedge clk);
    check_all(where);
  endtask

  initial begin
    model_reset();
    #20;
    check_all("rst");
    #31;
    reset = 1'b0;              // released at 51ns, first fetch at 55ns
    step("fetch0", 0, 2'b00, 0, 0);
    chk("fetch0.instr_is_word0", Instruction_id, tag(32'd0));
    step("fetch1", 0, 2'b00, 0, 0);
    chk("fetch1.pc_is_8", PC, 32'h8);
    step("stall0", 1, 2'b00, 0, 0);
    step("stall1", 1, 2'b00, 0, 0);
    step("resume0", 0, 2'b00, 0, 0);
    chk("resume0.pc_is_c", PC, 32'hC);
    step("resume1", 0, 2'b00, 0, 0);
    step("jal", 0, 2'b01, 32'h40, 32'h1234);
    chk("jal.nop", Instruction_id, 32'h13);
    step("jal_next", 0, 2'b00, 0, 0);
    chk("jal_next.word40", Instruction_id, tag(32'h40));
    step("both_stall", 1, 2'b11, 32'h40, 32'h80);
    chk("both_stall.pc80", PC, 32'h80);
    step("after_both", 0, 2'b00, 0, 0);
    step("ex_align", 0, 2'b10, 32'h0, 32'hFFFF_FFFE);
    chk("ex_align.pc", PC, 32'hFFFF_FFFC);
    step("wrap", 0, 2'b00, 0, 0);
    chk("wrap.pc0", PC, 32'h0);
    step("wrap_id", 0, 2'b00, 0, 0);
    step("id_unaligned", 1, 2'b01, 32'h0000_0243, 0);
    step("id_unaligned_next", 0, 2'b00, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic        st;
      logic [1:0]  jf;
      st = ($urandom_range(0, 3) == 0);
      jf = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step("rand", st, jf, $urandom, $urandom);
    end

    // asynchronous reset between edges, while a redirect is being presented
    Stall = 1'b0; JumpFlag = 2'b10; JumpTarget_ex = 32'h0000_0500;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #29;
    check_all("async_rst_hold");
    Stall = 1'b0; JumpFlag = 2'b00;
    reset = 1'b0;
    step("post_rst0", 0, 2'b00, 0, 0);
    step("post_rst1", 0, 2'b00, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step("rand2", ($urandom_range(0, 4) == 0), 2'b00, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
